motor_cmd_sched: RTL
====================

MOTOR_CMD_SCHED -- requirements
Module: motor_cmd_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning cycles allowed from start assertion to mot_ack high.
REQ-003 SHALL have parameters MIN_HIGH/MAX_HIGH, defaults 19'd33000/19'd82500, meaning clamp bounds for pulse high time (1.0/2.5 ms at 33 MHz).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports wr_en  in  1  and wr_data  in  19, meaning push one high-time command.
REQ-007 SHALL have port flush  in  1, meaning discard all queued commands.
REQ-008 SHALL have ports clr_ovf  in  1  and clr_tmo  in  1, meaning clear sticky flags.
REQ-009 SHALL have ports full  out  1, count  out  $clog2(DEPTH)+1, overflow  out  1, timeout  out  1.
REQ-010 SHALL have port mot_control  out  32: bit31 start, bits[18:0] high time, other bits 0.
REQ-011 SHALL have port mot_ack  in  1: pulse unit high from command accept until burst end.
REQ-012 SHALL have ports busy  out  1 and done  out  1 (one-cycle pulse per completed burst).

Function
REQ-013 FIFO SHALL accept wr_en when not full; wr_en while full SHALL drop data and set overflow.
REQ-014 Simultaneous write and pop on a full FIFO SHALL accept the write; count unchanged.
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL equal entries held (0..DEPTH).
REQ-016 FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-017 IDLE: if count>0 and mot_ack==0, pop head, latch into mot_control[18:0], assert bit31, go ISSUE next cycle.
REQ-018 IDLE with mot_ack==1 (unit still finishing) SHALL wait; no pop.
REQ-019 ISSUE: bit31 held high; on mot_ack==1 deassert bit31 same edge, go WAIT_DONE.
REQ-020 ISSUE: if mot_ack still 0 after ACK_TIMEOUT cycles, deassert bit31, set timeout, discard command, go IDLE.
REQ-021 WAIT_DONE: on mot_ack==0, pulse done for one cycle, go IDLE.
REQ-022 Minimum latency wr_en into empty idle FIFO to bit31 high: 2 cycles.
REQ-023 busy SHALL be high whenever state!=IDLE or count>0.
REQ-024 flush SHALL empty FIFO in one cycle; SHALL NOT abort an in-flight ISSUE/WAIT_DONE command; flush with wr_en same cycle: flush wins, write dropped, overflow unaffected.
REQ-025 Sticky flags: set and clear in same cycle SHALL leave flag set.
REQ-026 mot_control[18:0] SHALL hold value stable from ISSUE entry until next pop.

Reset
REQ-027 resetn low SHALL asynchronously force IDLE, FIFO empty, mot_control=0, overflow=0, timeout=0, done=0, full=0, busy=0.
REQ-028 Reset mid-burst SHALL drop bit31 immediately; pulse unit resets on same resetn.

Configuration
REQ-029 With MOTOR_SCHED_CLAMP_EN defined, popped high time SHALL be clamped to [MIN_HIGH, MAX_HIGH] before driving mot_control.
REQ-030 Without MOTOR_SCHED_CLAMP_EN, high time SHALL pass unmodified; MIN_HIGH/MAX_HIGH ignored.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, MOT_START_BIT=31, MOT_HIGH_W=19, default clamp constants.
REQ-032 FIFO SHALL be sub-module motor_cmd_fifo (DEPTH, width 19, push/pop/flush, full/empty/count).

Verification
REQ-033 Push 50000 into idle, mot_ack model rises 2 cycles after start, falls 100 later -> bit31 high 2 cycles after wr_en, low on ack edge, done pulse once, busy low after.
REQ-034 Push 5 commands, DEPTH=4, unit stalled -> 5th dropped, overflow=1, count=4; clr_ovf -> overflow=0.
REQ-035 mot_ack never rises -> bit31 deasserts after 16 cycles, timeout=1, next command issued.
REQ-036 CLAMP_EN: push 1000 and 100000 -> mot_control[18:0]=33000 then 82500; without macro -> 1000, 100000.
REQ-037 flush during WAIT_DONE with 3 queued -> count=0, current burst completes with done, then IDLE.
REQ-038 resetn low during ISSUE -> mot_control=0, count=0 without clock edge.

Source files
------------

// File: rtl/motor_cmd_sched_pkg.sv
// motor_cmd_sched_pkg
// Shared definitions for the motor command scheduler: scheduler state
// encoding, mot_control field positions and default pulse-width bounds.
// Configuration macro MOTOR_SCHED_CLAMP_EN is consumed by motor_cmd_sched.
package motor_cmd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  localparam int MOT_START_BIT = 31;
  localparam int MOT_HIGH_W    = 19;

  // 1.0 ms / 2.5 ms of high time at 33 MHz
  localparam logic [MOT_HIGH_W-1:0] DEF_MIN_HIGH = 19'd33000;
  localparam logic [MOT_HIGH_W-1:0] DEF_MAX_HIGH = 19'd82500;

endpackage

// File: rtl/motor_cmd_fifo.sv
// motor_cmd_fifo
// Circular command queue holding pulse high-time values.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   push, push_data      write one entry (accepted when not full, or when
//                        full and a pop happens in the same cycle)
//   pop                  remove the head entry (ignored when empty)
//   flush                empty the queue; overrides push and pop
//   pop_data             current head entry
//   full, empty, count   occupancy status (count = 0..DEPTH)
module motor_cmd_fifo
  import motor_cmd_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = MOT_HIGH_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // A pop frees the slot the simultaneous push needs, so a full queue
  // still accepts the write in that case.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/motor_cmd_sched.sv
// motor_cmd_sched
// Queues pulse high-time commands and hands them one at a time to a motor
// pulse unit through a start/ack handshake, with an ack timeout.
// Optional build macro: MOTOR_SCHED_CLAMP_EN -- clamp each popped high time
// to [MIN_HIGH, MAX_HIGH]; without it the value passes unmodified.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   wr_en, wr_data     push one 19-bit high-time command
//   flush              discard all queued commands (in-flight one continues)
//   clr_ovf, clr_tmo   clear the sticky overflow / timeout flags
//   full, count        queue status
//   overflow, timeout  sticky error flags
//   mot_control        bit31 start, bits[18:0] high time, others zero
//   mot_ack            pulse unit busy, high from accept until burst end
//   busy               command active or queued
//   done               one-cycle pulse per completed burst
module motor_cmd_sched
  import motor_cmd_sched_pkg::*;
#(
  parameter int                    DEPTH       = 4,
  parameter int                    ACK_TIMEOUT = 16,
  parameter logic [MOT_HIGH_W-1:0] MIN_HIGH    = DEF_MIN_HIGH,
  parameter logic [MOT_HIGH_W-1:0] MAX_HIGH    = DEF_MAX_HIGH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [MOT_HIGH_W-1:0]   wr_data,
  input  logic                    flush,
  input  logic                    clr_ovf,
  input  logic                    clr_tmo,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    timeout,
  output logic [31:0]             mot_control,
  input  logic                    mot_ack,
  output logic                    busy,
  output logic                    done
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  sched_state_t          state;
  sched_state_t          state_nxt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [MOT_HIGH_W-1:0] head;
  logic [MOT_HIGH_W-1:0] high_sel;
  logic [MOT_HIGH_W-1:0] high_q;
  logic [TW-1:0]         tmo_cnt;
  logic                  pop;
  logic                  tmo_hit;
  logic                  done_set;
  logic                  ovf_set;

  motor_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MOT_HIGH_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

`ifdef MOTOR_SCHED_CLAMP_EN
  function automatic logic [MOT_HIGH_W-1:0] clamp_high(input logic [MOT_HIGH_W-1:0] v);
    if (v < MIN_HIGH) return MIN_HIGH;
    if (v > MAX_HIGH) return MAX_HIGH;
    return v;
  endfunction

  assign high_sel = clamp_high(head);
`else
  // Bounds are accepted for interface compatibility but have no effect here.
  logic [MOT_HIGH_W-1:0] unused_bounds;
  assign unused_bounds = MIN_HIGH ^ MAX_HIGH;
  assign high_sel      = head;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (pop)               state_nxt = ST_ISSUE;
      ST_ISSUE:     if (mot_ack)           state_nxt = ST_WAIT_DONE;
                    else if (tmo_hit)      state_nxt = ST_IDLE;
      ST_WAIT_DONE: if (!mot_ack)          state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // A flush in the same cycle suppresses the pop so the discarded head is
  // never issued. mot_ack high in IDLE means the unit is still finishing.
  always_comb begin
    pop      = (state == ST_IDLE) && !fifo_empty && !mot_ack && !flush;
    tmo_hit  = (state == ST_ISSUE) && !mot_ack && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    done_set = (state == ST_WAIT_DONE) && !mot_ack;
    ovf_set  = wr_en && !flush && fifo_full && !pop;

    mot_control                          = '0;
    mot_control[MOT_START_BIT]           = (state == ST_ISSUE);
    mot_control[MOT_HIGH_W-1:0]          = high_q;

    busy     = (state != ST_IDLE) || !fifo_empty;
    full     = fifo_full;
  end

  // High time stays latched after the burst until the next pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      high_q   <= '0;
      tmo_cnt  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (pop) high_q <= high_sel;

      if (pop)                              tmo_cnt <= '0;
      else if (state == ST_ISSUE && !mot_ack) tmo_cnt <= tmo_cnt + 1'b1;

      done <= done_set;

      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (tmo_hit)      timeout <= 1'b1;
      else if (clr_tmo) timeout <= 1'b0;
    end
  end

endmodule
